// File: rtl/sfifo_nettlp.sv
// Single-clock parametrised FIFO with count, watermarks and overflow/underflow pulses.
// Define SFIFO_NETTLP_FWFT_EN for first-word-fall-through; otherwise standard registered read.
module sfifo_nettlp #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 7,
  parameter int AF_LEVEL      = 124,
  parameter int AE_LEVEL      = 4
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int          CW    = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     ram_rd;
  logic                     empty_nxt;
  logic [CW-1:0]            count_nxt;

`ifdef SFIFO_NETTLP_FWFT_EN
  // count covers RAM words plus the head word parked in the output register.
  logic          out_valid;
  logic          out_valid_nxt;
  logic [CW-1:0] ram_cnt;

  always_comb begin
    rd_acc        = rd_en & out_valid;
    wr_acc        = wr_en & (~full | rd_acc);
    ram_cnt       = count - CW'(out_valid);
    ram_rd        = (ram_cnt != '0) & (~out_valid | rd_acc);
    out_valid_nxt = ram_rd | (out_valid & ~rd_acc);
    empty_nxt     = ~out_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid_nxt;
    end
  end
`else
  always_comb begin
    rd_acc    = rd_en & ~empty;
    wr_acc    = wr_en & (~full | rd_acc);
    ram_rd    = rd_acc;
    empty_nxt = (count_nxt == '0);
  end
`endif

  always_comb begin
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (srst_n && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      count        <= count_nxt;
      empty        <= empty_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      overflow     <= wr_en & ~wr_acc;
      underflow    <= rd_en & ~rd_acc;
    end
  end

endmodule

// File: tb/tb_sfifo_nettlp.sv
// Self-checking bench for sfifo_nettlp in standard mode with default parameters.
module tb_sfifo_nettlp;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        wr_en;
  logic [63:0] din;
  logic        rd_en;
  logic [63:0] dout;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic [7:0]  count;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [63:0] q[$];
  logic [63:0] exp_dout;
  logic        exp_ov;
  logic        exp_uf;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         e_count;
    logic       e_empty;
    logic       e_uf;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  sfifo_nettlp #(
    .DATA_WIDTH   (64),
    .ADDRESS_WIDTH(7),
    .AF_LEVEL     (124),
    .AE_LEVEL     (4)
  ) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, "_count"}, 64'(count), 64'(n));
    chk({tag, "_empty"}, 64'(empty), 64'(n == 0));
    chk({tag, "_full"}, 64'(full), 64'(n == 128));
    chk({tag, "_af"}, 64'(almost_full), 64'(n >= 124));
    chk({tag, "_ae"}, 64'(almost_empty), 64'(n <= 4));
    chk({tag, "_ov"}, 64'(overflow), 64'(exp_ov));
    chk({tag, "_uf"}, 64'(underflow), 64'(exp_uf));
    chk({tag, "_dout"}, dout, exp_dout);
  endtask

  task automatic cyc(input logic w, input logic r, input logic [63:0] d,
                     input bit model_chk, input string tag);
    bit ra;
    bit wa;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    ra     = r && (q.size() > 0);
    wa     = w && ((q.size() < 128) || ra);
    exp_uf = r && !ra;
    exp_ov = w && !wa;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (model_chk) check_model(tag);
  endtask

  task automatic do_reset(input logic w);
    @(negedge clk);
    srst_n = 1'b0;
    wr_en  = w;
    din    = 64'hDEAD;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    wr_en  = 1'b0;
    q.delete();
    exp_dout = '0;
    exp_ov   = 1'b0;
    exp_uf   = 1'b0;
  endtask

  initial begin
    tbl[0] = '{w: 1'b1, r: 1'b0, d: 8'h11, e_count: 1, e_empty: 1'b0, e_uf: 1'b0, e_dout: 8'h00};
    tbl[1] = '{w: 1'b1, r: 1'b1, d: 8'h22, e_count: 1, e_empty: 1'b0, e_uf: 1'b0, e_dout: 8'h11};
    tbl[2] = '{w: 1'b0, r: 1'b1, d: 8'h00, e_count: 0, e_empty: 1'b1, e_uf: 1'b0, e_dout: 8'h22};
    tbl[3] = '{w: 1'b0, r: 1'b1, d: 8'h00, e_count: 0, e_empty: 1'b1, e_uf: 1'b1, e_dout: 8'h22};
    tbl[4] = '{w: 1'b0, r: 1'b0, d: 8'h00, e_count: 0, e_empty: 1'b1, e_uf: 1'b0, e_dout: 8'h22};
    tbl[5] = '{w: 1'b1, r: 1'b1, d: 8'h55, e_count: 1, e_empty: 1'b0, e_uf: 1'b1, e_dout: 8'h22};
    tbl[6] = '{w: 1'b0, r: 1'b1, d: 8'h00, e_count: 0, e_empty: 1'b1, e_uf: 1'b0, e_dout: 8'h55};

    srst_n = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    check_model("reset");

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].w, tbl[i].r, 64'(tbl[i].d), 1'b0, "");
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(tbl[i].e_empty));
      chk($sformatf("vec%0d_uf", i), 64'(underflow), 64'(tbl[i].e_uf));
      chk($sformatf("vec%0d_dout", i), dout, 64'(tbl[i].e_dout));
    end

    for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, 64'(i), 1'b1, "fill");
    chk("fill_full_hand", 64'(full), 64'd1);
    cyc(1'b1, 1'b0, 64'hFF, 1'b1, "overflow");
    chk("overflow_hand", 64'(overflow), 64'd1);
    cyc(1'b0, 1'b0, 64'h0, 1'b1, "overflow_end");

    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 1'b1, 64'h0, 1'b1, "drain");
      chk("drain_seq", dout, 64'(i));
    end
    cyc(1'b0, 1'b1, 64'h0, 1'b1, "underflow");
    chk("underflow_dout_hold", dout, 64'h7F);
    cyc(1'b0, 1'b0, 64'h0, 1'b1, "underflow_end");

    for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, 64'(8'h80 + i), 1'b1, "refill");
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 64'(8'hA0 + k), 1'b1, "fullconc");
      chk("fullconc_dout", dout, 64'(8'h80 + k));
    end
    for (int i = 0; i < 128; i++) cyc(1'b0, 1'b1, 64'h0, 1'b1, "fullconc_drain");

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 64'(1000 * pass + i), 1'b1, "wrap_wr");
      for (int i = 0; i < 100; i++) begin
        cyc(1'b0, 1'b1, 64'h0, 1'b1, "wrap_rd");
        chk("wrap_data", dout, 64'(1000 * pass + i));
      end
    end
    chk("wrap_count_zero", 64'(count), 64'd0);

    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 64'(8'h40 + i), 1'b1, "pre_rst");
    chk("pre_rst_count", 64'(count), 64'd60);
    do_reset(1'b1);
    check_model("midrst");
    chk("midrst_dout_hand", dout, 64'd0);
    cyc(1'b1, 1'b0, 64'h77, 1'b1, "post_rst_wr");
    cyc(1'b0, 1'b1, 64'h0, 1'b1, "post_rst_rd");
    chk("post_rst_data", dout, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
